// File: rtl/pipeline_ctrl.sv
// Hazard and flow-control sequencer for the 5-stage pipeline: load-use bubbles, branch/jump
// flushes, data-memory freeze, halt drain, and saturating bring-up event counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_rs_id,
  input  logic [3:0]       i_rt_id,
  input  logic             i_use_rs_id,
  input  logic             i_use_rt_id,
  input  logic [3:0]       i_rd_id_ex,
  input  logic             i_mem_rd_id_ex,
  input  logic             i_br_taken_id_ex,
  input  logic             i_jmp_id_ex,
  input  logic             i_hlt_id,
  input  logic             i_dm_busy,
  output logic             o_stall,
  output logic             o_flow_change,
  output logic             o_flush_im_id,
  output logic             o_flush_id_ex,
  output logic             o_freeze,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cnt_lu,
  output logic [CNT_W-1:0] o_cnt_flush,
  output logic [CNT_W-1:0] o_cnt_mem
);

  localparam int unsigned DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0] DrainInit = DW'(DRAIN_CYC);

  typedef enum logic [1:0] {StRun = 2'd0, StDrain = 2'd1, StHalted = 2'd2} state_e;

  state_e           r_state, w_state_nxt;
  logic [DW-1:0]    r_drain, w_drain_nxt;
  logic [CNT_W-1:0] r_cnt_lu, r_cnt_flush, r_cnt_mem;

  logic w_lu_hit, w_flow_req;
  logic w_rule_mem, w_rule_flow, w_rule_lu, w_rule_hlt;

  assign w_lu_hit = i_mem_rd_id_ex && (i_rd_id_ex != 4'd0) &&
                    ((i_use_rs_id && (i_rs_id == i_rd_id_ex)) ||
                     (i_use_rt_id && (i_rt_id == i_rd_id_ex)));
  assign w_flow_req = i_br_taken_id_ex || i_jmp_id_ex;

  // Priority chain in RUN; the memory freeze also applies while draining.
  assign w_rule_mem  = (r_state != StHalted) && i_dm_busy;
  assign w_rule_flow = (r_state == StRun) && !i_dm_busy && w_flow_req;
  assign w_rule_lu   = (r_state == StRun) && !i_dm_busy && !w_flow_req && w_lu_hit;
  assign w_rule_hlt  = (r_state == StRun) && !i_dm_busy && !w_flow_req && !w_lu_hit && i_hlt_id;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StRun;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    unique case (r_state)
      StRun: begin
        if (w_rule_hlt) begin
          w_state_nxt = StDrain;
          w_drain_nxt = DrainInit;
        end
      end
      StDrain: begin
        // The counter reaching zero on this edge ends the drain.
        if (!i_dm_busy) begin
          if (r_drain <= DW'(1)) w_state_nxt = StHalted;
          w_drain_nxt = (r_drain == '0) ? '0 : r_drain - DW'(1);
        end
      end
      StHalted: w_state_nxt = StHalted;
      default:  w_state_nxt = StRun;
    endcase
  end

  always_comb begin
    o_stall       = 1'b0;
    o_flow_change = 1'b0;
    o_flush_im_id = 1'b0;
    o_flush_id_ex = 1'b0;
    o_freeze      = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        StRun: begin
          if (w_rule_mem) begin
            o_freeze = 1'b1;
            o_stall  = 1'b1;
          end else if (w_rule_flow) begin
            o_flow_change = 1'b1;
            o_flush_im_id = 1'b1;
            o_flush_id_ex = 1'b1;
          end else if (w_rule_lu) begin
            o_stall       = 1'b1;
            o_flush_id_ex = 1'b1;
          end
        end
        StDrain: begin
          o_stall       = 1'b1;
          o_flush_id_ex = 1'b1;
          o_freeze      = i_dm_busy;
        end
        StHalted: begin
          o_stall  = 1'b1;
          o_freeze = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_lu    <= '0;
      r_cnt_flush <= '0;
      r_cnt_mem   <= '0;
    end else begin
      if (w_rule_lu && (r_cnt_lu != '1))       r_cnt_lu    <= r_cnt_lu + 1'b1;
      if (w_rule_flow && (r_cnt_flush != '1))  r_cnt_flush <= r_cnt_flush + 1'b1;
      if (w_rule_mem && (r_cnt_mem != '1))     r_cnt_mem   <= r_cnt_mem + 1'b1;
    end
  end

  assign o_halted    = (r_state == StHalted) && !i_rst;
  assign o_cnt_lu    = r_cnt_lu;
  assign o_cnt_flush = r_cnt_flush;
  assign o_cnt_mem   = r_cnt_mem;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and flow-control sequencer for the 5-stage pipeline (IM, ID, EX, DM, WB). It owns every signal that steers the program counter and pipeline flops: the PC `stall` and `flow_change`, the IM/ID and ID/EX flush (bubble) enables, and a global freeze for data-memory wait states. It also drains the pipeline on a halt instruction and keeps saturating event counters for bring-up. The block sits beside the PC and pipeline flops in the top level and takes decode and EX-stage fields as inputs.

## Interface
- CNT_W, 16, width of each event counter
- DRAIN_CYC, 3, cycles from halt leaving ID until the halt has retired from WB
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rs_ID  in  4  source register 1 of the instruction in ID
- rt_ID  in  4  source register 2 of the instruction in ID
- use_rs_ID, use_rt_ID  in  1 each  the ID instruction actually reads rs or rt
- rd_ID_EX  in  4  destination register of the instruction in EX
- mem_rd_ID_EX  in  1  the EX instruction is a load
- br_taken_ID_EX  in  1  conditional branch in EX resolved taken
- jmp_ID_EX  in  1  jump or call in EX
- hlt_ID  in  1  the ID instruction is a halt
- dm_busy  in  1  data memory is not ready this cycle
- stall  out  1  PC and IM/ID flop hold
- flow_change  out  1  PC loads the EX destination
- flush_IM_ID  out  1  IM/ID flop loads a NOP
- flush_ID_EX  out  1  ID/EX flop loads a NOP
- freeze  out  1  every pipeline flop holds, including PC
- halted  out  1  the pipeline has fully drained after a halt
- cnt_lu, cnt_flush, cnt_mem  out  CNT_W each  counts of load-use bubbles, flow-change flushes, and memory-wait cycles

## Operation
- States are RUN, DRAIN, and HALTED, held in a 2-bit register with a drain counter sized for DRAIN_CYC.
- lu_hit = mem_rd_ID_EX & rd_ID_EX≠0 & ((use_rs_ID & rs_ID==rd_ID_EX) | (use_rt_ID & rt_ID==rd_ID_EX)).
- flow_req = br_taken_ID_EX | jmp_ID_EX.
- In RUN, the first matching rule wins (strict priority):
  1. dm_busy: freeze=1 and stall=1. No flush, flow_change=0. The branch waits in EX and is re-evaluated next cycle.
  2. flow_req: flow_change=1, flush_IM_ID=1, flush_ID_EX=1, stall=0. lu_hit and hlt_ID are ignored because they belong to the wrong path.
  3. lu_hit: stall=1 and flush_ID_EX=1, inserting one bubble. The hazard clears on its own the next cycle.
  4. hlt_ID: the halt advances normally this cycle. The next state is DRAIN with the counter set to DRAIN_CYC.
  5. Otherwise every output is 0.
- In DRAIN:
  - stall=1 and flush_ID_EX=1, so bubbles follow the halt.
  - flow_change, flush_IM_ID, and lu/hlt evaluation are suppressed.
  - dm_busy still asserts freeze and pauses the counter.
  - When the counter is 0, the next state is HALTED.
- In HALTED: halted=1, stall=1, freeze=1, all other outputs 0. Only rst leaves this state.
- Counters increment by 1 per qualifying cycle and saturate at all-ones (no wrap):
  - cnt_lu: rule 3 taken.
  - cnt_flush: rule 2 taken.
  - cnt_mem: freeze due to dm_busy in RUN or DRAIN.
- Arithmetic is unsigned. A register 0 destination never creates a hazard.

## Timing
- Outputs other than halted and the counters are combinational from the inputs and state, with zero latency, and are valid before the same clock edge the flops sample.
- halted and the counters are registered.
- Reset value of every output is 0; state is RUN and the counters are 0. While rst=1, all outputs are forced to 0.
- rst asserted mid-DRAIN or in HALTED returns to RUN asynchronously. The counters clear.
- A load-use hazard costs exactly 1 bubble. A taken branch or jump costs 2 flushed slots. Halt to halted=1 takes DRAIN_CYC+1 edges with dm_busy low.
- dm_busy together with flow_req: the flow change is deferred, not lost, and fires on the first cycle dm_busy=0 if flow_req is still high.
- lu_hit together with flow_req: only the flush is applied, and cnt_lu does not increment.

## Test plan
- Load-use hazard: rd_ID_EX=5, mem_rd_ID_EX=1, rs_ID=5, use_rs_ID=1 for one cycle -> stall=1 and flush_ID_EX=1 for that cycle only, cnt_lu=1. Repeat with rd=0 -> no stall.
- Taken branch: br_taken_ID_EX=1 for one cycle -> flow_change=1, flush_IM_ID=1, flush_ID_EX=1, stall=0, cnt_flush=1. Same cycle with lu_hit=1 -> stall=0, cnt_lu unchanged.
- Memory wait over a jump: jmp_ID_EX=1 with dm_busy=1 for 3 cycles, then 0 -> freeze=1 and flow_change=0 for 3 cycles, flow_change=1 on the 4th, cnt_mem=3.
- Halt drain: hlt_ID=1 for one cycle -> stall=0 that cycle, stall=1 and flush_ID_EX=1 for 3 cycles, halted=1 after the 4th edge and held. Insert one dm_busy cycle mid-drain -> halted delayed by 1.
- Wrong-path halt: hlt_ID=1 with br_taken_ID_EX=1 -> stays in RUN, halted never asserts.
- Reset and saturation: assert rst in HALTED -> all outputs 0 immediately, RUN after release. Hold lu_hit for 65540 cycles -> cnt_lu=0xFFFF and holds.
